// File: rtl/rs_pkg.sv
// Shared definitions for the 4-symbol-per-clock RS(255,239) encoder:
// GF(2^8) arithmetic, the generator polynomial and the FSM state type.
package rs_pkg;

  localparam int SYM_W     = 8;
  localparam int PAR_WORDS = 4;
  localparam int PAR_SYMS  = 4 * PAR_WORDS;
  localparam int WORD_W    = 4 * SYM_W;

  localparam logic [8:0] PRIM_POLY = 9'h11D;

  typedef enum logic [1:0] {
    IDLE,
    MSG,
    PAR
  } state_t;

  // Carry-less shift-and-add multiply reduced by the primitive polynomial.
  // With a constant operand this collapses to a small XOR network.
  function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                              input logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] acc;
    logic [SYM_W-1:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) acc = acc ^ x;
      x = x[SYM_W-1] ? ({x[SYM_W-2:0], 1'b0} ^ PRIM_POLY[SYM_W-1:0])
                     : {x[SYM_W-2:0], 1'b0};
    end
    return acc;
  endfunction

  // g(x) = prod (x + a^i), i = 0..15; the monic x^16 term is implicit.
  function automatic logic [PAR_SYMS-1:0][SYM_W-1:0] gen_poly();
    logic [PAR_SYMS:0][SYM_W-1:0] g;
    logic [SYM_W-1:0]             root;
    g    = '0;
    g[0] = 8'h01;
    root = 8'h01;
    for (int i = 0; i < PAR_SYMS; i++) begin
      for (int j = PAR_SYMS; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, 8'h02);
    end
    return g[PAR_SYMS-1:0];
  endfunction

  // G_COEF[i] is the coefficient of x^i.
  localparam logic [PAR_SYMS-1:0][SYM_W-1:0] G_COEF = gen_poly();

endpackage

// File: rtl/rs_encoder_x4_if.sv
// Word stream into and out of the RS encoder.
// Optional frame_err member present when RS_FRAME_ERR_EN is defined.
interface rs_encoder_x4_if;

  logic                      en;
  logic                      frame_start_in;
  logic [rs_pkg::WORD_W-1:0] din;
  logic [rs_pkg::WORD_W-1:0] dout;
  logic                      frame_start_out;
`ifdef RS_FRAME_ERR_EN
  logic                      frame_err;

  modport master (output en, frame_start_in, din,
                  input  dout, frame_start_out, frame_err);
  modport slave  (input  en, frame_start_in, din,
                  output dout, frame_start_out, frame_err);
`else
  modport master (output en, frame_start_in, din,
                  input  dout, frame_start_out);
  modport slave  (input  en, frame_start_in, din,
                  output dout, frame_start_out);
`endif

endinterface

// File: rtl/rs_lfsr_x4.sv
// Next state of the 16-symbol parity LFSR after absorbing one 4-symbol word,
// the MSB symbol first: four serial division steps unrolled into logic.
module rs_lfsr_x4
  import rs_pkg::*;
(
  input  logic [PAR_SYMS-1:0][SYM_W-1:0] lfsr_cur,
  input  logic [WORD_W-1:0]              din,
  output logic [PAR_SYMS-1:0][SYM_W-1:0] lfsr_next
);

  logic [PAR_SYMS-1:0][SYM_W-1:0] r;
  logic [SYM_W-1:0]               fb;

  // Four chained steps; each feeds back (symbol + top cell) times g(x).
  always_comb begin
    r  = lfsr_cur;
    fb = '0;
    for (int s = 0; s < 4; s++) begin
      fb = din[WORD_W-1-SYM_W*s -: SYM_W] ^ r[PAR_SYMS-1];
      for (int j = PAR_SYMS-1; j > 0; j--) r[j] = r[j-1] ^ gf_mul(fb, G_COEF[j]);
      r[0] = gf_mul(fb, G_COEF[0]);
    end
    lfsr_next = r;
  end

endmodule

// File: rtl/rs_encoder_x4.sv
// Systematic shortened RS(255,239) encoder, 4 symbols per clock.
// Message words pass through with one cycle of latency, then four parity
// words follow, highest-degree symbol first.
// Optional: define RS_FRAME_ERR_EN to add frame_err (start aborted a frame).
//
// state | meaning
// IDLE  | no frame open; dout follows din one cycle later, LFSR held
// MSG   | absorbing message words, counter 0..MSG_WORDS-1
// PAR   | shifting parity out of the LFSR, counter 0..PAR_WORDS-1
module rs_encoder_x4
  import rs_pkg::*;
#(
  parameter int MSG_WORDS = 59
) (
  input  logic          clk,
  input  logic          rst_n,
  rs_encoder_x4_if.slave bus
);

  localparam int CNT_W = $clog2((MSG_WORDS > PAR_WORDS) ? MSG_WORDS : PAR_WORDS);
  localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_WORDS - 1);
  localparam logic [CNT_W-1:0] PAR_LAST = CNT_W'(PAR_WORDS - 1);

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [PAR_SYMS-1:0][SYM_W-1:0] lfsr_q, lfsr_d;
  logic [PAR_SYMS-1:0][SYM_W-1:0] lfsr_base, lfsr_absorb;
  logic [WORD_W-1:0]              dout_q, dout_d;
  logic                           fso_q, fso_d;

  // A frame start absorbs its first word into a cleared register.
  assign lfsr_base = bus.frame_start_in ? '0 : lfsr_q;

  rs_lfsr_x4 u_lfsr (
    .lfsr_cur  (lfsr_base),
    .din       (bus.din),
    .lfsr_next (lfsr_absorb)
  );

  // Next state, counter, LFSR and output word; everything holds when en=0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    dout_d  = dout_q;
    fso_d   = fso_q;
    if (bus.en) begin
      fso_d = bus.frame_start_in;
      if (bus.frame_start_in) begin
        state_d = MSG;
        cnt_d   = CNT_W'(1);
        lfsr_d  = lfsr_absorb;
        dout_d  = bus.din;
      end else begin
        case (state_q)
          IDLE: dout_d = bus.din;
          MSG: begin
            lfsr_d = lfsr_absorb;
            dout_d = bus.din;
            if (cnt_q == MSG_LAST) begin
              state_d = PAR;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          PAR: begin
            // Shift the top four cells out; the register drains to zero.
            dout_d = lfsr_q[PAR_SYMS-1 -: 4];
            lfsr_d = {lfsr_q[PAR_SYMS-5:0], {WORD_W{1'b0}}};
            if (cnt_q == PAR_LAST) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lfsr_q  <= '0;
      dout_q  <= '0;
      fso_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      dout_q  <= dout_d;
      fso_q   <= fso_d;
    end
  end

  assign bus.dout            = dout_q;
  assign bus.frame_start_out = fso_q;

`ifdef RS_FRAME_ERR_EN
  logic err_q;

  // Pulse alongside frame_start_out when the start cut a frame short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_q <= 1'b0;
    else if (bus.en) err_q <= bus.frame_start_in && (state_q != IDLE);
  end

  assign bus.frame_err = err_q;
`endif

endmodule

// File: tb/tb_rs_encoder_x4.sv
// Bench for rs_encoder_x4: random frames checked against a polynomial
// long-division model and a syndrome check on the emitted codeword.
module tb_rs_encoder_x4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rs_encoder_x4_if bus_if ();

  rs_encoder_x4 #(.MSG_WORDS(59)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  exp_t [0:511];
  int          log_t [0:255];
  logic [7:0]  g_full [0:16];
  logic [31:0] msg_a [0:58];
  logic [31:0] exp_a [0:62];
  logic [31:0] cw_obs [0:62];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'd0 || b == 8'd0) return 8'd0;
    return exp_t[log_t[a] + log_t[b]];
  endfunction

  task automatic init_gf();
    int x;
    x = 1;
    for (int i = 0; i < 512; i++) begin
      exp_t[i] = x[7:0];
      x = x << 1;
      if (x > 255) x = x ^ 'h11D;
    end
    for (int i = 0; i < 256; i++) log_t[i] = 0;
    for (int i = 0; i < 255; i++) log_t[exp_t[i]] = i;
    for (int k = 0; k <= 16; k++) g_full[k] = 8'd0;
    g_full[0] = 8'd1;
    for (int i = 0; i < 16; i++)
      for (int j = 16; j >= 0; j--)
        g_full[j] = gmul(g_full[j], exp_t[i]) ^ ((j > 0) ? g_full[j-1] : 8'd0);
  endtask

  // Full-length RS(255,239): 3 zero symbols, 236 message symbols, 16 zeros;
  // the remainder of the long division by g(x) is the parity.
  task automatic compute_exp();
    logic [7:0] d [0:254];
    logic [7:0] c;
    for (int i = 0; i < 255; i++) d[i] = 8'd0;
    for (int w = 0; w < 59; w++)
      for (int s = 0; s < 4; s++) d[3 + 4*w + s] = msg_a[w][31 - 8*s -: 8];
    for (int i = 0; i < 239; i++) begin
      c = d[i];
      if (c != 8'd0)
        for (int j = 1; j <= 16; j++) d[i+j] = d[i+j] ^ gmul(c, g_full[16-j]);
    end
    for (int w = 0; w < 59; w++) exp_a[w] = msg_a[w];
    for (int k = 0; k < 4; k++)
      exp_a[59+k] = {d[239+4*k], d[240+4*k], d[241+4*k], d[242+4*k]};
  endtask

  task automatic cyc(input bit e, input bit fs, input logic [31:0] d,
                     output logic [31:0] o, output logic f);
    bus_if.en             = e;
    bus_if.frame_start_in = fs;
    bus_if.din            = d;
    @(posedge clk);
    #1;
    o = bus_if.dout;
    f = bus_if.frame_start_out;
  endtask

  task automatic run_frame(input string tag, input int n_words, input bit stall, input bit exp_err);
    logic [31:0] o;
    logic        f;
    for (int w = 0; w < n_words; w++) begin
      cyc(1'b1, w == 0, (w < 59) ? msg_a[w] : $urandom, o, f);
      cw_obs[w] = o;
      check_val($sformatf("%s_dout[%0d]", tag, w), o, exp_a[w]);
      check_val($sformatf("%s_fso[%0d]", tag, w), 32'(f), 32'(w == 0));
`ifdef RS_FRAME_ERR_EN
      check_val($sformatf("%s_err[%0d]", tag, w), 32'(bus_if.frame_err), 32'((w == 0) && exp_err));
`endif
      if (stall && w == 4) begin
        for (int s = 0; s < 10; s++) begin
          cyc(1'b0, 1'($urandom_range(0, 1)), $urandom, o, f);
          check_val($sformatf("%s_stall_dout[%0d]", tag, s), o, exp_a[4]);
          check_val($sformatf("%s_stall_fso[%0d]", tag, s), 32'(f), 32'd0);
        end
      end
    end
  endtask

  task automatic check_syndromes(input string tag);
    logic [7:0] acc;
    for (int i = 0; i < 16; i++) begin
      acc = 8'd0;
      for (int w = 0; w < 63; w++)
        for (int s = 0; s < 4; s++)
          acc = gmul(acc, exp_t[i]) ^ cw_obs[w][31 - 8*s -: 8];
      check_val($sformatf("%s_syndrome[%0d]", tag, i), 32'(acc), 32'd0);
    end
  endtask

  task automatic rand_msg();
    for (int w = 0; w < 59; w++) msg_a[w] = $urandom;
    compute_exp();
  endtask

  initial begin
    logic [31:0] o;
    logic        f;
    logic [31:0] d;

    init_gf();
    bus_if.en             = 1'b0;
    bus_if.frame_start_in = 1'b0;
    bus_if.din            = 32'd0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_dout", bus_if.dout, 32'd0);
    check_val("reset_fso", 32'(bus_if.frame_start_out), 32'd0);
`ifdef RS_FRAME_ERR_EN
    check_val("reset_err", 32'(bus_if.frame_err), 32'd0);
`endif
    rst_n = 1'b1;

    // IDLE passthrough
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      cyc(1'b1, 1'b0, d, o, f);
      check_val($sformatf("idle_dout[%0d]", i), o, d);
      check_val($sformatf("idle_fso[%0d]", i), 32'(f), 32'd0);
    end

    // All-zero message
    for (int w = 0; w < 59; w++) msg_a[w] = 32'd0;
    compute_exp();
    run_frame("zero", 63, 1'b0, 1'b0);

    // Single 0x01 in the last symbol: parity is g(x) without its x^16 term
    for (int w = 0; w < 59; w++) msg_a[w] = 32'd0;
    msg_a[58] = 32'h0000_0001;
    compute_exp();
    run_frame("unit", 63, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      check_val($sformatf("gcoef[%0d]", k), cw_obs[59+k],
                {g_full[15-4*k], g_full[14-4*k], g_full[13-4*k], g_full[12-4*k]});

    // Random frames, back-to-back
    for (int n = 0; n < 2; n++) begin
      rand_msg();
      run_frame($sformatf("rand%0d", n), 63, 1'b0, 1'b0);
      check_syndromes($sformatf("rand%0d", n));
    end

    // Stall mid-frame
    rand_msg();
    run_frame("stall", 63, 1'b1, 1'b0);
    check_syndromes("stall");

    // Abort at message word 20, new frame follows
    rand_msg();
    run_frame("abort_old", 20, 1'b0, 1'b0);
    rand_msg();
    run_frame("abort_new", 63, 1'b0, 1'b1);
    check_syndromes("abort_new");

    // Reset in the middle of the parity words
    rand_msg();
    run_frame("pre_rst", 61, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midpar_rst_dout", bus_if.dout, 32'd0);
    check_val("midpar_rst_fso", 32'(bus_if.frame_start_out), 32'd0);
    bus_if.en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rand_msg();
    run_frame("post_rst", 63, 1'b0, 1'b0);
    check_syndromes("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
